shift_reg_ctrl: RTL and testbench

SHIFT_REG_CTRL -- requirements
Module: shift_reg_ctrl

---
 rtl/shift_reg_ctrl_pkg.sv | 17 +
 rtl/shift_reg_ctrl_shifter.sv | 39 +++
 rtl/shift_reg_ctrl.sv | 157 +++++++++++++++
 tb/tb_shift_reg_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_ctrl_pkg.sv
// Shared configuration for the shift-register controller: default geometry
// macros and the counter-width helper used by the controller.
`ifndef ARRAYHEIGHT
`define ARRAYHEIGHT 4
`endif
`ifndef DATASIZE
`define DATASIZE 8
`endif

package shift_reg_ctrl_pkg;

    // Counters must hold the value DEPTH itself, not just DEPTH-1.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/shift_reg_ctrl_shifter.sv
// Word-wide shift register: load_en and out_en both advance the chain toward
// slot 0; slot 0 is presented on out, the tail takes in (or zero when draining).
module shifter_register #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic             out_en,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    logic [DEPTH-1:0][WIDTH-1:0] slot_reg;
    logic [DEPTH-1:0][WIDTH-1:0] slot_next;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            if (gi == DEPTH - 1) begin : g_tail
                assign slot_next[gi] = load_en ? in : '0;
            end else begin : g_body
                assign slot_next[gi] = slot_reg[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_reg <= '0;
        end else if (load_en || out_en) begin
            slot_reg <= slot_next;
        end
    end

    assign out = slot_reg[0];

endmodule

// File: rtl/shift_reg_ctrl.sv
// Block controller: loads up to DEPTH words into a shift register, zero-pads
// short blocks, then drains only the real words through a registered output.
`ifndef ARRAYHEIGHT
`define ARRAYHEIGHT 4
`endif
`ifndef DATASIZE
`define DATASIZE 8
`endif

module shift_reg_ctrl
    import shift_reg_ctrl_pkg::*;
#(
    parameter int DEPTH = `ARRAYHEIGHT,
    parameter int DW    = `DATASIZE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2*DW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2*DW-1:0] out_data,
    output logic          busy,
    output logic          done
);

    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_PAD   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    typedef enum logic [1:0] {
        S_LOAD  = ST_LOAD,
        S_PAD   = ST_PAD,
        S_DRAIN = ST_DRAIN,
        S_WAIT  = ST_WAIT
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   k_reg, k_next;
    logic [CW-1:0]   slot_reg, slot_next;
    logic [CW-1:0]   drain_reg, drain_next;
    logic            out_valid_reg;
    logic [2*DW-1:0] out_data_reg;
    logic            done_reg, done_next;

    logic            load_en;
    logic            out_en;
    logic [2*DW-1:0] sr_in;
    logic [2*DW-1:0] sr_out;
    logic            out_free;

    shifter_register #(
        .DEPTH (DEPTH),
        .WIDTH (2*DW)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load_en (load_en),
        .out_en  (out_en),
        .in      (sr_in),
        .out     (sr_out)
    );

    assign out_free = !out_valid_reg || out_ready;

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        slot_next  = slot_reg;
        drain_next = drain_reg;
        load_en    = 1'b0;
        out_en     = 1'b0;
        sr_in      = '0;
        in_ready   = 1'b0;
        done_next  = 1'b0;
        case (state_reg)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_en   = 1'b1;
                    sr_in     = in_data;
                    k_next    = k_reg + CW'(1);
                    slot_next = slot_reg + CW'(1);
                    // A full block goes straight to DRAIN even without in_last.
                    if (k_next == DEPTH_C) begin
                        state_next = S_DRAIN;
                        drain_next = k_next;
                    end else if (in_last) begin
                        state_next = S_PAD;
                    end
                end
            end
            S_PAD: begin
                load_en   = 1'b1;
                slot_next = slot_reg + CW'(1);
                if (slot_next == DEPTH_C) begin
                    state_next = S_DRAIN;
                    drain_next = k_reg;
                end
            end
            S_DRAIN: begin
                if (out_free) begin
                    out_en     = 1'b1;
                    drain_next = drain_reg - CW'(1);
                    if (drain_reg == CW'(1)) begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (out_free) begin
                    done_next  = 1'b1;
                    k_next     = '0;
                    slot_next  = '0;
                    state_next = S_LOAD;
                end
            end
            default: state_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_LOAD;
            k_reg         <= '0;
            slot_reg      <= '0;
            drain_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            done_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            slot_reg  <= slot_next;
            drain_reg <= drain_next;
            done_reg  <= done_next;
            if (out_en) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= sr_out;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign done      = done_reg;
    assign busy      = !(state_reg == S_LOAD && k_reg == '0);

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Directed bench for shift_reg_ctrl at DEPTH=4, DW=8 with hand-computed
// cycle-exact expectations per scenario.
module tb_shift_reg_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    shift_reg_ctrl #(
        .DEPTH (4),
        .DW    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Presents one word for one cycle; only called while the DUT is in LOAD.
    task automatic send(input logic [15:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        cyc();
        $display("  load word %h last=%b", d, last);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (out_data !== 16'h0000) begin
            failures++; $display("FAIL reset_out_data: got %h expected 0000", out_data);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL reset_busy_done: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_full_block();
        logic [15:0] w [4];
        w = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (in_ready !== 1'b1) begin
                failures++; $display("FAIL full_in_ready[%0d]: got %b expected 1", i, in_ready);
            end
            send(w[i], i == 3);
        end
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++; $display("FAIL full_busy: got busy=%b in_ready=%b expected 1 0", busy, in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (out_valid !== 1'b1 || out_data !== w[i]) begin
                failures++;
                $display("FAIL full_word[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, out_valid, out_data, w[i]);
            end else begin
                $display("  full block out word %h", out_data);
            end
        end
        cyc();
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL full_done: got done=%b valid=%b expected 1 0", done, out_valid);
        end
        cyc();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL full_done_pulse: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_short_block();
        out_ready = 1'b1;
        send(16'h00AA, 1'b0);
        send(16'h00BB, 1'b1);
        // Two PAD cycles, one DRAIN cycle, then the first word registers.
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                failures++; $display("FAIL short_pad[%0d]: got valid=%b in_ready=%b expected 0 0", i, out_valid, in_ready);
            end
            cyc();
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h00AA) begin
            failures++; $display("FAIL short_word0: got valid=%b data=%h expected 1 00aa", out_valid, out_data);
        end else $display("  short block out word %h", out_data);
        cyc();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h00BB) begin
            failures++; $display("FAIL short_word1: got valid=%b data=%h expected 1 00bb", out_valid, out_data);
        end else $display("  short block out word %h", out_data);
        cyc();
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b1) begin
            failures++; $display("FAIL short_no_pad_out: got valid=%b done=%b expected 0 1", out_valid, done);
        end
        cyc();
    endtask

    task automatic test_backpressure();
        logic [15:0] w [4];
        w = '{16'h1010, 16'h2020, 16'h3030, 16'h4040};
        out_ready = 1'b1;
        // No in_last: reaching four words alone must start the drain.
        for (int i = 0; i < 4; i++) send(w[i], 1'b0);
        cyc();
        checks++;
        if (out_valid !== 1'b1 || out_data !== w[0]) begin
            failures++; $display("FAIL bp_word0: got valid=%b data=%h expected 1 %h", out_valid, out_data, w[0]);
        end else $display("  backpressure out word %h", out_data);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (out_valid !== 1'b1 || out_data !== w[0]) begin
                failures++; $display("FAIL bp_hold[%0d]: got valid=%b data=%h expected 1 %h", i, out_valid, out_data, w[0]);
            end
        end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            cyc();
            checks++;
            if (out_valid !== 1'b1 || out_data !== w[i]) begin
                failures++; $display("FAIL bp_word[%0d]: got valid=%b data=%h expected 1 %h", i, out_valid, out_data, w[i]);
            end else $display("  backpressure out word %h", out_data);
        end
        cyc();
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b1) begin
            failures++; $display("FAIL bp_done: got valid=%b done=%b expected 0 1", out_valid, done);
        end
        cyc();
    endtask

    task automatic test_upstream_stall();
        int n_cyc;
        out_ready = 1'b1;
        send(16'h0055, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'h0066;
        in_last  = 1'b1;
        n_cyc    = 0;
        // Bounded: done is expected on the 5th edge.
        while (done !== 1'b1 && n_cyc < 20) begin
            checks++;
            if (in_ready !== 1'b0) begin
                failures++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", n_cyc, in_ready);
            end
            cyc();
            n_cyc++;
            if (n_cyc == 4) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 16'h0055) begin
                    failures++; $display("FAIL stall_word0: got valid=%b data=%h expected 1 0055", out_valid, out_data);
                end else $display("  stall out word %h", out_data);
            end
        end
        checks++;
        if (n_cyc != 5 || out_valid !== 1'b0) begin
            failures++; $display("FAIL stall_done_time: got cycles=%0d valid=%b expected 5 0", n_cyc, out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL stall_accept: got in_ready=%b expected 1", in_ready);
        end
        cyc();
        $display("  load word 0066 last=1 (held)");
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (4) cyc();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0066) begin
            failures++; $display("FAIL stall_word1: got valid=%b data=%h expected 1 0066", out_valid, out_data);
        end else $display("  stall out word %h", out_data);
        cyc();
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b1) begin
            failures++; $display("FAIL stall_done2: got valid=%b done=%b expected 0 1", out_valid, done);
        end
        cyc();
    endtask

    task automatic test_reset_mid_drain();
        out_ready = 1'b1;
        send(16'hA1A1, 1'b0);
        send(16'hB2B2, 1'b0);
        send(16'hC3C3, 1'b0);
        send(16'hD4D4, 1'b1);
        cyc();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hA1A1) begin
            failures++; $display("FAIL rmd_word0: got valid=%b data=%h expected 1 a1a1", out_valid, out_data);
        end else $display("  reset-mid out word %h", out_data);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL rmd_after_rst: got valid=%b in_ready=%b busy=%b expected 0 1 0", out_valid, in_ready, busy);
        end
        cyc();
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL rmd_no_done: got done=%b valid=%b expected 0 0", done, out_valid);
        end
        send(16'h1111, 1'b1);
        repeat (4) cyc();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h1111) begin
            failures++; $display("FAIL rmd_word1111: got valid=%b data=%h expected 1 1111", out_valid, out_data);
        end else $display("  reset-mid out word %h", out_data);
        cyc();
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b1) begin
            failures++; $display("FAIL rmd_done: got valid=%b done=%b expected 0 1", out_valid, done);
        end
        cyc();
    endtask

    task automatic test_single_word();
        out_ready = 1'b1;
        send(16'h7777, 1'b1);
        // Three PAD cycles and the DRAIN cycle with nothing on the output.
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b1) begin
                failures++; $display("FAIL single_pad[%0d]: got valid=%b busy=%b expected 0 1", i, out_valid, busy);
            end
            cyc();
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h7777) begin
            failures++; $display("FAIL single_word: got valid=%b data=%h expected 1 7777", out_valid, out_data);
        end else $display("  single out word %h", out_data);
        cyc();
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL single_done: got done=%b valid=%b expected 1 0", done, out_valid);
        end
        cyc();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL single_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_full_block();
        test_short_block();
        test_backpressure();
        test_upstream_stall();
        test_reset_mid_drain();
        test_single_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
